// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer BRAM arbiter for capture writes, display reads and
// edge-engine reads/writes, with aging and a read-return tag pipeline.
module fb_port_arbiter #(
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              cap_valid,
  output logic              cap_ready,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              edge_valid,
  output logic              edge_ready,
  input  logic              edge_we,
  input  logic [ADDR_W-1:0] edge_addr,
  input  logic [DATA_W-1:0] edge_wdata,
  output logic              edge_rvalid,
  output logic [DATA_W-1:0] edge_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       cap_stall
);

  localparam int unsigned CNT_W  = $clog2(STARVE_MAX + 1);
  localparam int unsigned PIPE_D = RD_LAT + 1;

  logic [CNT_W-1:0]  disp_wait;
  logic [CNT_W-1:0]  edge_wait;
  logic              disp_urgent;
  logic              edge_urgent;
  logic              cap_gnt;
  logic              disp_gnt;
  logic              edge_gnt;
  logic [PIPE_D-1:0] tag_disp;
  logic [PIPE_D-1:0] tag_edge;

  // Fixed-priority grant with starved requesters promoted above capture
  always_comb begin
    disp_urgent = (disp_wait == CNT_W'(STARVE_MAX));
    edge_urgent = (edge_wait == CNT_W'(STARVE_MAX));
    cap_gnt     = 1'b0;
    disp_gnt    = 1'b0;
    edge_gnt    = 1'b0;
    if (!reset) begin
      if (disp_valid && disp_urgent)      disp_gnt = 1'b1;
      else if (edge_valid && edge_urgent) edge_gnt = 1'b1;
      else if (cap_valid)                 cap_gnt  = 1'b1;
      else if (disp_valid)                disp_gnt = 1'b1;
      else if (edge_valid)                edge_gnt = 1'b1;
    end
  end

  assign cap_ready  = cap_gnt;
  assign disp_ready = disp_gnt;
  assign edge_ready = edge_gnt;

  // Wait counters: count blocked cycles, saturate at the starvation limit
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      disp_wait <= '0;
      edge_wait <= '0;
    end else begin
      if (!disp_valid || disp_gnt)
        disp_wait <= '0;
      else if (!disp_urgent)
        disp_wait <= disp_wait + CNT_W'(1);

      if (!edge_valid || edge_gnt)
        edge_wait <= '0;
      else if (!edge_urgent)
        edge_wait <= edge_wait + CNT_W'(1);
    end
  end

  // BRAM command register; address and write data hold on idle cycles
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= cap_gnt | disp_gnt | edge_gnt;
      mem_we <= cap_gnt | (edge_gnt & edge_we);
      if (cap_gnt) begin
        mem_addr  <= cap_addr;
        mem_wdata <= cap_data;
      end else if (disp_gnt) begin
        mem_addr  <= disp_addr;
      end else if (edge_gnt) begin
        mem_addr  <= edge_addr;
        mem_wdata <= edge_wdata;
      end
    end
  end

  // Read-owner tags travel alongside the BRAM latency
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      tag_disp <= '0;
      tag_edge <= '0;
    end else begin
      tag_disp <= {tag_disp[PIPE_D-2:0], disp_gnt};
      tag_edge <= {tag_edge[PIPE_D-2:0], edge_gnt & ~edge_we};
    end
  end

  assign disp_rvalid = tag_disp[PIPE_D-1];
  assign edge_rvalid = tag_edge[PIPE_D-1];
  assign disp_rdata  = mem_rdata;
  assign edge_rdata  = mem_rdata;

  always_ff @(posedge sys_clk) begin
    if (reset)
      cap_stall <= '0;
    else if (cap_valid && !cap_gnt && (cap_stall != 16'hFFFF))
      cap_stall <= cap_stall + 16'd1;
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed self-checking bench for fb_port_arbiter with a read-first,
// two-cycle-latency BRAM model.
module tb_fb_port_arbiter;

  localparam int unsigned ADDR_W     = 17;
  localparam int unsigned DATA_W     = 12;
  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned STARVE_MAX = 8;

  logic              sys_clk = 1'b0;
  logic              reset   = 1'b1;
  logic              cap_valid = 1'b0, cap_ready;
  logic [ADDR_W-1:0] cap_addr  = '0;
  logic [DATA_W-1:0] cap_data  = '0;
  logic              disp_valid = 1'b0, disp_ready, disp_rvalid;
  logic [ADDR_W-1:0] disp_addr  = '0;
  logic [DATA_W-1:0] disp_rdata;
  logic              edge_valid = 1'b0, edge_ready, edge_we = 1'b0, edge_rvalid;
  logic [ADDR_W-1:0] edge_addr  = '0;
  logic [DATA_W-1:0] edge_wdata = '0;
  logic [DATA_W-1:0] edge_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [15:0]       cap_stall;

  int n_cmp = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  fb_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .sys_clk(sys_clk), .reset(reset),
    .cap_valid(cap_valid), .cap_ready(cap_ready), .cap_addr(cap_addr), .cap_data(cap_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_addr(disp_addr),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .edge_valid(edge_valid), .edge_ready(edge_ready), .edge_we(edge_we),
    .edge_addr(edge_addr), .edge_wdata(edge_wdata),
    .edge_rvalid(edge_rvalid), .edge_rdata(edge_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cap_stall(cap_stall)
  );

  // Read-first BRAM, two registered read stages
  logic [DATA_W-1:0] bram [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_s0, rd_s1;
  always @(posedge sys_clk) begin
    if (mem_en) begin
      rd_s0 <= bram[mem_addr];
      if (mem_we) bram[mem_addr] <= mem_wdata;
    end
    rd_s1 <= rd_s0;
  end
  assign mem_rdata = rd_s1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_all();
    cap_valid  = 1'b0;
    disp_valid = 1'b0;
    edge_valid = 1'b0;
    edge_we    = 1'b0;
  endtask

  task automatic do_reset();
    idle_all();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Test 5 op table: kind 0 = display read, 1 = edge read, 2 = edge write;
  // data is the write data or the hand-derived read-back value.
  localparam int N5 = 7;
  logic [1:0]        op_k [N5];
  logic [ADDR_W-1:0] op_a [N5];
  logic [DATA_W-1:0] op_d [N5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bram[17'h100] = 12'h3C7;
    op_k = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd1};
    op_a = '{17'h200, 17'h100, 17'h200, 17'h201, 17'h200, 17'h201, 17'h100};
    op_d = '{12'h111, 12'h3C7, 12'h111, 12'h222, 12'h111, 12'h222, 12'h3C7};

    // 1: reset with all valids high, then release
    reset = 1'b1; cap_valid = 1'b1; disp_valid = 1'b1; edge_valid = 1'b1;
    cyc(); cyc(); settle();
    check_val("t1_cap_ready_rst",  32'(cap_ready), 32'd0);
    check_val("t1_disp_ready_rst", 32'(disp_ready), 32'd0);
    check_val("t1_edge_ready_rst", 32'(edge_ready), 32'd0);
    check_val("t1_mem_en_rst",     32'(mem_en), 32'd0);
    check_val("t1_mem_we_rst",     32'(mem_we), 32'd0);
    check_val("t1_mem_addr_rst",   32'(mem_addr), 32'd0);
    check_val("t1_cap_stall_rst",  32'(cap_stall), 32'd0);
    cyc(); reset = 1'b0; settle();
    check_val("t1_cap_ready_rel",  32'(cap_ready), 32'd1);
    check_val("t1_disp_ready_rel", 32'(disp_ready), 32'd0);
    check_val("t1_edge_ready_rel", 32'(edge_ready), 32'd0);

    // 2: capture burst to addresses 0..3
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i < 4) begin
        cap_valid = 1'b1;
        cap_addr  = ADDR_W'(i);
        cap_data  = DATA_W'(12'hA50 + i);
      end else begin
        cap_valid = 1'b0;
      end
      settle();
      if (i < 4) check_val("t2_cap_ready", 32'(cap_ready), 32'd1);
      if (i >= 1 && i <= 4) begin
        check_val("t2_mem_en",    32'(mem_en), 32'd1);
        check_val("t2_mem_we",    32'(mem_we), 32'd1);
        check_val("t2_mem_addr",  32'(mem_addr), 32'(i - 1));
        check_val("t2_mem_wdata", 32'(mem_wdata), 32'(12'hA50 + i - 1));
      end
      if (i == 5) begin
        check_val("t2_idle_en",    32'(mem_en), 32'd0);
        check_val("t2_idle_we",    32'(mem_we), 32'd0);
        check_val("t2_hold_addr",  32'(mem_addr), 32'd3);
        check_val("t2_hold_wdata", 32'(mem_wdata), 32'hA53);
      end
    end
    check_val("t2_cap_stall", 32'(cap_stall), 32'd0);

    // 3: single display read, return three cycles after accept
    do_reset();
    cyc(); disp_valid = 1'b1; disp_addr = 17'h100; settle();
    check_val("t3_disp_ready", 32'(disp_ready), 32'd1);
    cyc(); disp_valid = 1'b0; settle();
    check_val("t3_mem_en",   32'(mem_en), 32'd1);
    check_val("t3_mem_we",   32'(mem_we), 32'd0);
    check_val("t3_mem_addr", 32'(mem_addr), 32'h100);
    check_val("t3_rvalid_c1", 32'(disp_rvalid), 32'd0);
    cyc(); settle();
    check_val("t3_rvalid_c2", 32'(disp_rvalid), 32'd0);
    cyc(); settle();
    check_val("t3_rvalid_c3", 32'(disp_rvalid), 32'd1);
    check_val("t3_rdata",     32'(disp_rdata), 32'h3C7);
    check_val("t3_edge_rv",   32'(edge_rvalid), 32'd0);
    cyc(); settle();
    check_val("t3_rvalid_c4", 32'(disp_rvalid), 32'd0);

    // 4: capture vs display starvation
    do_reset();
    for (int k = 0; k < 9; k++) begin
      cyc();
      if (k == 0) begin
        cap_valid = 1'b1; cap_addr = 17'h10; cap_data = 12'h001;
        disp_valid = 1'b1; disp_addr = 17'h100;
      end
      settle();
      check_val("t4_cap_ready",  32'(cap_ready), 32'(k < 8));
      check_val("t4_disp_ready", 32'(disp_ready), 32'(k == 8));
    end
    cyc(); disp_valid = 1'b0; settle();
    check_val("t4_cap_resume", 32'(cap_ready), 32'd1);
    check_val("t4_cap_stall",  32'(cap_stall), 32'd1);
    cyc(); cap_valid = 1'b0; settle();
    check_val("t4_cap_stall_hold", 32'(cap_stall), 32'd1);

    // 4b: all three held; urgent display beats urgent edge, edge stays urgent
    do_reset();
    for (int k = 0; k < 11; k++) begin
      cyc();
      if (k == 0) begin
        cap_valid = 1'b1; cap_addr = 17'h20; cap_data = 12'h002;
        disp_valid = 1'b1; disp_addr = 17'h100;
        edge_valid = 1'b1; edge_we = 1'b0; edge_addr = 17'h100;
      end
      if (k == 9)  disp_valid = 1'b0;
      if (k == 10) edge_valid = 1'b0;
      settle();
      check_val("t4b_cap_ready",  32'(cap_ready),  32'(k < 8 || k == 10));
      check_val("t4b_disp_ready", 32'(disp_ready), 32'(k == 8));
      check_val("t4b_edge_ready", 32'(edge_ready), 32'(k == 9));
    end
    cyc(); cap_valid = 1'b0; settle();
    check_val("t4b_cap_stall", 32'(cap_stall), 32'd2);

    // 5: interleaved edge reads/writes and display reads
    do_reset();
    for (int t = 0; t < 12; t++) begin
      int j;
      logic exp_dv, exp_ev;
      cyc();
      idle_all();
      if (t < N5) begin
        if (op_k[t] == 2'd0) begin
          disp_valid = 1'b1; disp_addr = op_a[t];
        end else begin
          edge_valid = 1'b1; edge_we = (op_k[t] == 2'd2);
          edge_addr = op_a[t]; edge_wdata = op_d[t];
        end
      end
      settle();
      if (t < N5)
        check_val("t5_ready", 32'((op_k[t] == 2'd0) ? disp_ready : edge_ready), 32'd1);
      j = t - 3;
      exp_dv = (j >= 0) && (j < N5) && (op_k[j] == 2'd0);
      exp_ev = (j >= 0) && (j < N5) && (op_k[j] == 2'd1);
      check_val("t5_disp_rvalid", 32'(disp_rvalid), 32'(exp_dv));
      check_val("t5_edge_rvalid", 32'(edge_rvalid), 32'(exp_ev));
      if (exp_dv) check_val("t5_disp_rdata", 32'(disp_rdata), 32'(op_d[j]));
      if (exp_ev) check_val("t5_edge_rdata", 32'(edge_rdata), 32'(op_d[j]));
    end

    // 6: reset discards reads in flight
    do_reset();
    for (int t = 0; t < 13; t++) begin
      cyc();
      idle_all();
      reset = 1'b0;
      case (t)
        0: begin disp_valid = 1'b1; disp_addr = 17'h100; end
        1: begin edge_valid = 1'b1; edge_we = 1'b0; edge_addr = 17'h200; end
        2: reset = 1'b1;
        8: begin disp_valid = 1'b1; disp_addr = 17'h100; end
        default: ;
      endcase
      settle();
      if (t >= 2) begin
        check_val("t6_disp_rvalid", 32'(disp_rvalid), 32'(t == 11));
        check_val("t6_edge_rvalid", 32'(edge_rvalid), 32'd0);
      end
      if (t == 11) check_val("t6_disp_rdata", 32'(disp_rdata), 32'h3C7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
